// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- oversampling UART receiver with a one-byte holding register.
//
// A frame is one start bit (low), N data bits (LSB first) and one stop bit
// (high). The line is sampled OS times per bit. A free-running divider
// produces the sample tick once every DVSR clocks.
//
// Parameters
//   N     data bits per frame (5..8)
//   OS    sample ticks per bit (even, >= 4)
//   DVSR  clk cycles per sample tick (>= 2)
//
// Ports
//   clk        in   system clock, rising-edge active
//   rst        in   asynchronous active-low reset
//   rx         in   serial line, idle high, asynchronous to clk
//   rd         in   consumer pop / acknowledge of the held byte
//   dout       out  received byte, meaningful while valid = 1
//   valid      out  holding register full
//   frame_err  out  one-cycle pulse: stop bit sampled low
//   overrun    out  one-cycle pulse: good frame dropped, holding register full
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int N    = 8,
  parameter int OS   = 16,
  parameter int DVSR = 163
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx,
  input  logic         rd,
  output logic [N-1:0] dout,
  output logic         valid,
  output logic         frame_err,
  output logic         overrun
);

  localparam int CW = $clog2(DVSR);
  localparam int SW = $clog2(OS);
  localparam int NW = $clog2(N);

  localparam logic [CW-1:0] CNT_MAX = CW'(DVSR - 1);
  localparam logic [SW-1:0] S_LAST  = SW'(OS - 1);
  localparam logic [SW-1:0] S_MID   = SW'(OS / 2 - 1);
  localparam logic [NW-1:0] N_LAST  = NW'(N - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  // Synchronizer and edge-detect history. All reset to the idle line level
  // so that a line already low at reset release never looks like an edge.
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic rx_prev_q, rx_prev_d;
  logic rx_s;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [NW-1:0] n_q, n_d;
  logic [N-1:0]  sh_q, sh_d;

  logic [N-1:0]  dout_q, dout_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;

  assign rx_s = sync2_q;
  assign tick = (cnt_q == CNT_MAX);

  always_comb begin
    sync1_d   = rx;
    sync2_d   = sync1_q;
    rx_prev_d = rx_s;
    cnt_d     = tick ? '0 : cnt_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    sh_d    = sh_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    // A pop empties the holding register; a load in the same cycle below
    // overrides this, so the register stays full with the new byte.
    if (rd && valid_q) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // Only a genuine 1->0 transition starts a frame; a line that is
        // merely held low (break, stuck line) is ignored.
        if (rx_prev_q && !rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end

      START: begin
        if (tick) begin
          if (s_q == S_MID) begin
            // Middle of the start bit: still low means a real start bit,
            // high means a glitch and the receiver quietly returns to idle.
            if (!rx_s) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (s_q == S_LAST) begin
            s_d  = '0;
            sh_d = {rx_s, sh_q[N-1:1]};
            if (n_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      STOP: begin
        if (tick) begin
          if (s_q == S_LAST) begin
            state_d = IDLE;
            s_d     = '0;
            if (rx_s) begin
              // Good frame: load if there is room, counting a same-cycle
              // pop as room; otherwise drop it and keep the held byte.
              if (!valid_q || rd) begin
                dout_d  = sh_q;
                valid_d = 1'b1;
              end else begin
                ovr_d = 1'b1;
              end
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        s_d     = '0;
        n_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      cnt_q     <= '0;
      state_q   <= IDLE;
      s_q       <= '0;
      n_q       <= '0;
      sh_q      <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      rx_prev_q <= rx_prev_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      sh_q      <= sh_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign dout      = dout_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx (N=8, OS=16, DVSR=4).
// Frames are driven bit-serially; a frame-level model of the holding
// register predicts dout/valid and the number of error/overrun pulses.
// Load timing is predicted from the tick grid: the tick counter restarts
// at reset release, so tick-action edges are those where the cycle index
// is DVSR-1 modulo DVSR.
// ---------------------------------------------------------------------------
module tb_uart_rx;
  localparam int N        = 8;
  localparam int OS       = 16;
  localparam int DVSR     = 4;
  localparam int BIT_CLKS = OS * DVSR;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rx  = 1'b1;
  logic         rd  = 1'b0;
  logic [N-1:0] dout;
  logic         valid;
  logic         frame_err;
  logic         overrun;

  uart_rx #(.N(N), .OS(OS), .DVSR(DVSR)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rd(rd),
    .dout(dout), .valid(valid), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // cyc equals the index of the next rising edge since reset release.
  int cyc = 0;
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // Output event monitor, sampled on the falling edge.
  int   rise_cnt = 0, fall_cnt = 0, fe_cnt = 0, ov_cnt = 0;
  int   both_cnt = 0, long_cnt = 0;
  int   rise_cyc = -1, fe_cyc = -1, ov_cyc = -1;
  logic valid_prev = 1'b0, fe_prev = 1'b0, ov_prev = 1'b0;

  always @(negedge clk) begin
    if (valid && !valid_prev) begin
      rise_cnt <= rise_cnt + 1;
      rise_cyc <= cyc;
    end
    if (!valid && valid_prev) fall_cnt <= fall_cnt + 1;
    if (frame_err) begin
      fe_cnt <= fe_cnt + 1;
      fe_cyc <= cyc;
    end
    if (overrun) begin
      ov_cnt <= ov_cnt + 1;
      ov_cyc <= cyc;
    end
    if (frame_err && overrun) both_cnt <= both_cnt + 1;
    if ((frame_err && fe_prev) || (overrun && ov_prev)) long_cnt <= long_cnt + 1;
    valid_prev <= valid;
    fe_prev    <= frame_err;
    ov_prev    <= overrun;
  end

  // Frame-level reference model of the holding register.
  logic         exp_valid = 1'b0;
  logic [N-1:0] exp_dout  = '0;
  int           exp_fe = 0, exp_ov = 0, exp_rise = 0, exp_fall = 0;

  task automatic model_frame(input logic [N-1:0] data, input logic stop, input bit rd_load);
    if (!stop) begin
      exp_fe++;
      if (rd_load && exp_valid) begin
        exp_valid = 1'b0;
        exp_fall++;
      end
    end else if (!exp_valid) begin
      exp_valid = 1'b1;
      exp_dout  = data;
      exp_rise++;
    end else if (rd_load) begin
      exp_dout = data;
    end else begin
      exp_ov++;
    end
  endtask

  task automatic pop();
    @(negedge clk) rd = 1'b1;
    @(negedge clk) rd = 1'b0;
    if (exp_valid) begin
      exp_valid = 1'b0;
      exp_fall++;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame. e_cyc is the edge index of the stop-sample tick;
  // rd_load raises rd in the cycle that ends on that edge. abort_bit >= 0
  // stops driving at the start of that bit position (0 = start bit).
  task automatic send_frame(input logic [N-1:0] data, input logic stop, input bit rd_load,
                            input int abort_bit, output int e_cyc);
    int p, t;
    logic [N+1:0] bits;
    bits = {stop, data, 1'b0};
    @(negedge clk);
    p = cyc;
    // rx_s sees the fall two edges after p; START begins after edge p+2.
    t = p + 3;
    while (t % DVSR != DVSR - 1) t++;
    e_cyc = t + (OS / 2 + N * OS + OS - 1) * DVSR;
    for (int b = 0; b < N + 2; b++) begin
      if (b == abort_bit) begin
        rd = 1'b0;
        return;
      end
      for (int i = 0; i < BIT_CLKS; i++) begin
        if (!(b == 0 && i == 0)) @(negedge clk);
        rx = bits[b];
        rd = (rd_load && cyc == e_cyc);
      end
    end
    rd = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    checks++; if (dout !== '0)        begin errors++; $display("FAIL reset_dout: got %h want 00", dout); end
    checks++; if (valid !== 1'b0)     begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle(20);
  endtask

  task automatic test_basic();
    int e;
    send_frame(8'hA5, 1'b1, 1'b0, -1, e);
    model_frame(8'hA5, 1'b1, 1'b0);
    idle(10);
    checks++; if (rise_cyc !== e + 1) begin errors++; $display("FAIL basic_latency: got %0d want %0d", rise_cyc, e + 1); end
    checks++; if (dout !== 8'hA5)     begin errors++; $display("FAIL basic_dout: got %h want a5", dout); end
    checks++; if (valid !== 1'b1)     begin errors++; $display("FAIL basic_valid: got %b want 1", valid); end
    checks++; if (fe_cnt !== exp_fe)  begin errors++; $display("FAIL basic_frame_err: got %0d want %0d", fe_cnt, exp_fe); end
    pop();
    checks++; if (valid !== 1'b0)     begin errors++; $display("FAIL basic_pop_valid: got %b want 0", valid); end
    checks++; if (dout !== 8'hA5)     begin errors++; $display("FAIL basic_dout_hold: got %h want a5", dout); end
    idle(20);
  endtask

  task automatic test_glitch();
    int e;
    @(negedge clk) rx = 1'b0;
    repeat (8) @(negedge clk);
    idle(60);
    checks++; if (valid !== exp_valid)   begin errors++; $display("FAIL glitch_valid: got %b want %b", valid, exp_valid); end
    checks++; if (fe_cnt !== exp_fe)     begin errors++; $display("FAIL glitch_frame_err: got %0d want %0d", fe_cnt, exp_fe); end
    checks++; if (ov_cnt !== exp_ov)     begin errors++; $display("FAIL glitch_overrun: got %0d want %0d", ov_cnt, exp_ov); end
    checks++; if (rise_cnt !== exp_rise) begin errors++; $display("FAIL glitch_rise: got %0d want %0d", rise_cnt, exp_rise); end
    send_frame(8'h69, 1'b1, 1'b0, -1, e);
    model_frame(8'h69, 1'b1, 1'b0);
    idle(10);
    checks++; if (dout !== exp_dout)     begin errors++; $display("FAIL glitch_recover_dout: got %h want %h", dout, exp_dout); end
    pop();
    idle(10);
  endtask

  task automatic test_frame_err();
    int e;
    send_frame(8'h3C, 1'b0, 1'b0, -1, e);
    model_frame(8'h3C, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (10 * BIT_CLKS) @(negedge clk);
    checks++; if (fe_cnt !== exp_fe)     begin errors++; $display("FAIL ferr_count: got %0d want %0d", fe_cnt, exp_fe); end
    checks++; if (fe_cyc !== e + 1)      begin errors++; $display("FAIL ferr_timing: got %0d want %0d", fe_cyc, e + 1); end
    checks++; if (valid !== 1'b0)        begin errors++; $display("FAIL ferr_valid: got %b want 0", valid); end
    checks++; if (rise_cnt !== exp_rise) begin errors++; $display("FAIL ferr_no_frames: got %0d want %0d", rise_cnt, exp_rise); end
    idle(BIT_CLKS);
    send_frame(8'h81, 1'b1, 1'b0, -1, e);
    model_frame(8'h81, 1'b1, 1'b0);
    idle(10);
    checks++; if (dout !== 8'h81)        begin errors++; $display("FAIL ferr_recover_dout: got %h want 81", dout); end
    pop();
    idle(10);
  endtask

  task automatic test_overrun();
    int e1, e2;
    send_frame(8'h11, 1'b1, 1'b0, -1, e1);
    model_frame(8'h11, 1'b1, 1'b0);
    idle(20);
    send_frame(8'h22, 1'b1, 1'b0, -1, e2);
    model_frame(8'h22, 1'b1, 1'b0);
    idle(10);
    checks++; if (dout !== 8'h11)     begin errors++; $display("FAIL ovr_dout: got %h want 11", dout); end
    checks++; if (valid !== 1'b1)     begin errors++; $display("FAIL ovr_valid: got %b want 1", valid); end
    checks++; if (ov_cnt !== exp_ov)  begin errors++; $display("FAIL ovr_count: got %0d want %0d", ov_cnt, exp_ov); end
    checks++; if (ov_cyc !== e2 + 1)  begin errors++; $display("FAIL ovr_timing: got %0d want %0d", ov_cyc, e2 + 1); end
    checks++; if (fe_cnt !== exp_fe)  begin errors++; $display("FAIL ovr_frame_err: got %0d want %0d", fe_cnt, exp_fe); end
    pop();
    idle(10);
  endtask

  task automatic test_rd_on_load();
    int e1, e2;
    send_frame(8'h11, 1'b1, 1'b0, -1, e1);
    model_frame(8'h11, 1'b1, 1'b0);
    idle(20);
    send_frame(8'h22, 1'b1, 1'b1, -1, e2);
    model_frame(8'h22, 1'b1, 1'b1);
    idle(10);
    checks++; if (dout !== 8'h22)        begin errors++; $display("FAIL rdload_dout: got %h want 22", dout); end
    checks++; if (valid !== 1'b1)        begin errors++; $display("FAIL rdload_valid: got %b want 1", valid); end
    checks++; if (ov_cnt !== exp_ov)     begin errors++; $display("FAIL rdload_overrun: got %0d want %0d", ov_cnt, exp_ov); end
    checks++; if (fall_cnt !== exp_fall) begin errors++; $display("FAIL rdload_no_drop: got %0d want %0d", fall_cnt, exp_fall); end
    pop();
    idle(10);
  endtask

  task automatic test_reset_mid();
    int e;
    send_frame(8'h33, 1'b1, 1'b0, -1, e);
    model_frame(8'h33, 1'b1, 1'b0);
    idle(10);
    send_frame(8'h77, 1'b1, 1'b0, 4, e);
    repeat (BIT_CLKS / 2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (dout !== '0)        begin errors++; $display("FAIL midrst_dout: got %h want 00", dout); end
    checks++; if (valid !== 1'b0)     begin errors++; $display("FAIL midrst_valid: got %b want 0", valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL midrst_frame_err: got %b want 0", frame_err); end
    checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL midrst_overrun: got %b want 0", overrun); end
    if (exp_valid) exp_fall++;
    exp_valid = 1'b0;
    exp_dout  = '0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle(20);
    send_frame(8'h5A, 1'b1, 1'b0, -1, e);
    model_frame(8'h5A, 1'b1, 1'b0);
    idle(10);
    checks++; if (dout !== 8'h5A)     begin errors++; $display("FAIL midrst_dout_after: got %h want 5a", dout); end
    checks++; if (valid !== 1'b1)     begin errors++; $display("FAIL midrst_valid_after: got %b want 1", valid); end
    checks++; if (rise_cyc !== e + 1) begin errors++; $display("FAIL midrst_latency: got %0d want %0d", rise_cyc, e + 1); end
    pop();
    idle(10);
  endtask

  task automatic test_random();
    int e;
    logic [N-1:0] data;
    logic stop;
    bit rdl;
    for (int k = 0; k < 14; k++) begin
      data = N'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      rdl  = ($urandom_range(0, 2) == 0);
      send_frame(data, stop, rdl, -1, e);
      model_frame(data, stop, rdl);
      idle($urandom_range(2, 50));
      checks++; if (dout !== exp_dout)     begin errors++; $display("FAIL rand_dout[%0d]: got %h want %h", k, dout, exp_dout); end
      checks++; if (valid !== exp_valid)   begin errors++; $display("FAIL rand_valid[%0d]: got %b want %b", k, valid, exp_valid); end
      checks++; if (fe_cnt !== exp_fe)     begin errors++; $display("FAIL rand_frame_err[%0d]: got %0d want %0d", k, fe_cnt, exp_fe); end
      checks++; if (ov_cnt !== exp_ov)     begin errors++; $display("FAIL rand_overrun[%0d]: got %0d want %0d", k, ov_cnt, exp_ov); end
      checks++; if (rise_cnt !== exp_rise) begin errors++; $display("FAIL rand_rise[%0d]: got %0d want %0d", k, rise_cnt, exp_rise); end
      if ($urandom_range(0, 1) == 1) pop();
    end
    idle(10);
  endtask

  task automatic test_pulse_rules();
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL pulses_exclusive: got %0d want 0", both_cnt); end
    checks++; if (long_cnt !== 0) begin errors++; $display("FAIL pulses_one_cycle: got %0d want 0", long_cnt); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_rd_on_load();
    test_reset_mid();
    test_random();
    test_pulse_rules();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter N, default 8: data bits per frame, range 5..8.
REQ-002 Parameter OS, default 16: sample ticks per bit; even, >= 4.
REQ-003 Parameter DVSR, default 163: clk cycles per sample tick, >= 2.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; asynchronous assertion, active-low, synchronous deassertion assumed at top level.
REQ-006 rx  input  1  serial line, idle high, asynchronous to clk.
REQ-007 rd  input  1  consumer pop/acknowledge of the held byte.
REQ-008 dout  output  N  received byte, valid while valid=1.
REQ-009 valid  output  1  holding register full.
REQ-010 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 overrun  output  1  one-cycle pulse: good frame dropped because the holding register was full.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer; rx_s denotes its output, and all rx references below use rx_s.
REQ-013 Tick counter SHALL count 0..DVSR-1, free-running and wrapping; tick=1 for the one cycle where count==DVSR-1.
REQ-014 The FSM SHALL have the states IDLE, START, DATA and STOP, a sample counter s (0..OS-1) and a bit counter n (0..N-1).
REQ-015 IDLE: on an rx_s 1->0 transition (previous rx_s=1, current rx_s=0), the FSM SHALL go to START with s=0; a steady low SHALL NOT start a frame.
REQ-016 START: on each tick s SHALL increment; on the tick with s==OS/2-1, rx_s=0 -> DATA with s=0, n=0; rx_s=1 -> IDLE, and no output changes (glitch rejection).
REQ-017 DATA: on the tick with s==OS-1, rx_s SHALL shift into the shift register LSB-first (right shift, MSB gets rx_s), and s SHALL reset to 0.
REQ-018 DATA: when n==N-1, that same shift event SHALL move the FSM to STOP; otherwise n SHALL increment.
REQ-019 STOP: on the tick with s==OS-1, the FSM SHALL return to IDLE and evaluate rx_s per REQ-020..REQ-022.
REQ-020 Stop rx_s=1, valid=0 or rd=1 that cycle: next cycle dout=shift register and valid=1.
REQ-021 Stop rx_s=1, valid=1 and rd=0: byte dropped, dout and valid unchanged, overrun=1 for one cycle.
REQ-022 Stop rx_s=0: byte discarded, frame_err=1 for one cycle, dout/valid/overrun unaffected.
REQ-023 Latency: valid SHALL rise exactly one clk after the stop-sample tick cycle.
REQ-024 rd with valid=1 and no simultaneous load SHALL clear valid next cycle; rd with valid=0 SHALL be ignored.
REQ-025 frame_err and overrun SHALL NOT both assert in the same cycle.
REQ-026 dout SHALL hold its value while valid=0 and SHALL change only on a load.

Reset
REQ-027 With rst=0: state=IDLE, s=0, n=0, tick counter=0, shift register=0, synchronizer flops=1.
REQ-028 With rst=0: dout=0, valid=0, frame_err=0, overrun=0, all taking effect immediately without waiting for clk.
REQ-029 A reset mid-frame SHALL abandon the frame; after release, the next 1->0 edge on rx_s starts a fresh frame.

Verification (DVSR=4, OS=16, N=8: 64 clks/bit)
REQ-030 Frame 0xA5, stop=1 -> valid=1 one clk after the stop tick, dout=0xA5, frame_err=0; pulse rd -> valid=0 next cycle.
REQ-031 rx low for 8 clks, then high -> FSM back to IDLE; valid, frame_err and overrun all stay 0.
REQ-032 Frame 0x3C, stop=0, then rx held low for 10 bit times -> exactly one frame_err pulse, valid=0, no further frames until rx rises and falls again.
REQ-033 Frames 0x11 then 0x22, no rd -> dout=0x11, valid=1, overrun pulses once at the second stop tick.
REQ-034 As REQ-033 but rd=1 in the second load cycle -> dout=0x22, valid stays 1, overrun=0.
REQ-035 rst=0 during DATA bit 3 -> all outputs 0 immediately; after release, frame 0x5A -> dout=0x5A, valid=1.
